booth_divider_seq: RTL and testbench
====================================

Name: booth_divider_seq

Overview:
- Sequential unsigned restoring divider. It is the inverse companion of the sequential Booth multiplier.
- Accepts divisor and dividend serially over the same narrow data_in bus that the multiplier uses.
- Iterates one quotient bit per clock, then returns remainder and quotient over a shared data_out bus, one word per cycle.
- Contains its own controller FSM and datapath registers: A (partial remainder), Q (dividend/quotient), Y (divisor), and an iteration counter.

Parameters:
- WIDTH, 5, operand/result width in bits; legal range 2..16.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new division; sampled only in IDLE
- data_in  input  WIDTH  operand bus: divisor in LOAD_Y, dividend in LOAD_X
- busy  output  1  high in every state except IDLE
- out_valid  output  1  data_out holds a result word
- out_sel  output  1  0 = remainder on data_out, 1 = quotient on data_out
- data_out  output  WIDTH  result word; 0 when out_valid=0
- dz  output  1  divide-by-zero flag for the most recent operation

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; A, Q, Y, counter, dz, data_out, out_valid, out_sel, busy all 0. Reset asserted in any state aborts the operation immediately, with no output produced.
- FSM states: IDLE, LOAD_Y, LOAD_X, ITER, OUT_R, OUT_Q.
- IDLE:
  - start=1 at a rising edge -> LOAD_Y.
  - start=0 -> stay in IDLE.
- LOAD_Y: at the edge, Y <= data_in -> LOAD_X. data_in must carry the divisor for this entire cycle.
- LOAD_X: at the edge:
  - Q <= data_in; A <= 0; counter <= WIDTH; dz <= 0.
  - If Y==0: dz <= 1, A <= data_in, Q <= all ones, then go to OUT_R (ITER skipped).
  - Otherwise -> ITER.
- A is WIDTH+1 bits wide, so the trial subtraction never overflows.
- ITER, once per cycle:
  - Form S = {A[WIDTH-1:0], Q[WIDTH-1]} and T = S - {1'b0, Y}.
  - If T[WIDTH]==0: A <= T, Q <= {Q[WIDTH-2:0], 1}.
  - Else: A <= S, Q <= {Q[WIDTH-2:0], 0}.
  - counter <= counter-1. When the pre-decrement counter is 1 -> OUT_R.
  - Exactly WIDTH ITER cycles.
- OUT_R (one cycle): out_valid=1, out_sel=0, data_out=A[WIDTH-1:0] -> OUT_Q.
- OUT_Q (one cycle): out_valid=1, out_sel=1, data_out=Q -> IDLE.
- All outputs are registered.
- Latency, with start sampled at edge k:
  - Normal division: remainder valid in the cycle after edge k+WIDTH+3; quotient one cycle later; busy low after edge k+WIDTH+5.
  - Divide by zero: remainder appears in the cycle after edge k+3.
- start while busy=1 is ignored (no queueing). start high in the OUT_Q cycle is also ignored. start held high continuously re-triggers from IDLE, giving back-to-back operations separated by one IDLE cycle.
- dz holds its value until the next LOAD_X, so it remains readable in IDLE.
- Invariants after a normal division: quotient*divisor + remainder == dividend; remainder < divisor.

Test Plan:
- Reset then idle -> busy=0, out_valid=0, data_out=0, dz=0; start=0 keeps the FSM in IDLE for 20 cycles.
- WIDTH=5: divisor 4, dividend 13 -> after 5 ITER cycles: OUT_R data_out=1, OUT_Q data_out=3, dz=0; check exact cycle count from start.
- Boundaries: 31/1 -> r=0, q=31. 7/9 -> r=7, q=0. 31/31 -> r=0, q=1. 0/5 -> r=0, q=0.
- Divisor 0, dividend 20 -> ITER skipped: OUT_R data_out=20, OUT_Q data_out=31, dz=1 held in IDLE; the next valid division clears dz.
- rst_n pulsed low mid-ITER -> immediate IDLE with all outputs 0 and no out_valid pulse; a following 13/4 operation returns r=1, q=3.
- start pulsed during ITER is ignored. start held high yields consecutive operations with one IDLE cycle between them. Exhaustive random check of all 32x31 non-zero-divisor pairs against the invariants.

Source files
------------

// File: rtl/booth_divider_seq_if.sv
// Operand/result bus of the sequential divider: serial operand input,
// start request, and time-shared remainder/quotient output.
interface booth_divider_seq_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             out_valid;
  logic             out_sel;
  logic [WIDTH-1:0] data_out;
  logic             dz;

  modport master (
    output start, data_in,
    input  busy, out_valid, out_sel, data_out, dz
  );

  modport slave (
    input  start, data_in,
    output busy, out_valid, out_sel, data_out, dz
  );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential unsigned restoring divider: divisor then dividend arrive on
// data_in, one quotient bit per clock, remainder then quotient on data_out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; dz from the last operation stays visible
// S_LOAD_Y | capture divisor from data_in
// S_LOAD_X | capture dividend, arm counter; divisor 0 skips to S_OUT_R
// S_ITER   | one restoring shift/subtract step per cycle, WIDTH cycles
// S_OUT_R  | present remainder (out_sel=0) on the next cycle
// S_OUT_Q  | present quotient (out_sel=1) on the next cycle
module booth_divider_seq #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input logic                clk,
  input logic                rst_n,
  booth_divider_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_LOAD_X,
    S_ITER,
    S_OUT_R,
    S_OUT_Q
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_q, a_nxt;
  logic [WIDTH-1:0] q_q, q_nxt;
  logic [WIDTH-1:0] y_q, y_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             dz_q, dz_nxt;
  logic             busy_q, busy_nxt;
  logic             valid_q, valid_nxt;
  logic             sel_q, sel_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;

  // A is one bit wider than the divisor so the trial subtraction cannot wrap
  logic [WIDTH:0] s_w;
  logic [WIDTH:0] t_w;

  assign s_w = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign t_w = s_w - {1'b0, y_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state   <= state_nxt;
      a_q     <= a_nxt;
      q_q     <= q_nxt;
      y_q     <= y_nxt;
      cnt_q   <= cnt_nxt;
      dz_q    <= dz_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      sel_q   <= sel_nxt;
      dout_q  <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    q_nxt     = q_q;
    y_nxt     = y_q;
    cnt_nxt   = cnt_q;
    dz_nxt    = dz_q;
    busy_nxt  = (state != S_IDLE);
    valid_nxt = 1'b0;
    sel_nxt   = 1'b0;
    dout_nxt  = '0;

    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        y_nxt     = bus.data_in;
        state_nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        q_nxt   = bus.data_in;
        a_nxt   = '0;
        cnt_nxt = CNT_W'(WIDTH);
        dz_nxt  = 1'b0;
        if (y_q == '0) begin
          // divide by zero: remainder = dividend, quotient = all ones
          dz_nxt    = 1'b1;
          a_nxt     = {1'b0, bus.data_in};
          q_nxt     = '1;
          state_nxt = S_OUT_R;
        end else begin
          state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        if (!t_w[WIDTH]) begin
          a_nxt = t_w;
          q_nxt = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          a_nxt = s_w;
          q_nxt = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_nxt = S_OUT_R;
      end
      S_OUT_R: begin
        valid_nxt = 1'b1;
        sel_nxt   = 1'b0;
        dout_nxt  = WIDTH'(a_q);
        state_nxt = S_OUT_Q;
      end
      S_OUT_Q: begin
        valid_nxt = 1'b1;
        sel_nxt   = 1'b1;
        dout_nxt  = q_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sel   = sel_q;
  assign bus.data_out  = dout_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed and exhaustive checks of booth_divider_seq at WIDTH=5.
module tb_booth_divider_seq;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  booth_divider_seq_if #(.WIDTH(W)) bus ();

  booth_divider_seq #(.WIDTH(W), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives one operation; lat is the number of edges after the start edge
  // until the remainder is visible (capped at 40 if out_valid never rises).
  task automatic run_div(input logic [W-1:0] dvs, input logic [W-1:0] dvd, input int pulse_m,
                         output logic [W-1:0] r, output logic [W-1:0] q,
                         output logic sel_r, output logic sel_q, output logic v_q,
                         output logic dzf, output int lat);
    int m;
    @(negedge clk); bus.start = 1'b1; bus.data_in = dvs;
    @(negedge clk); m = 0; bus.start = 1'b0; bus.data_in = dvs;
    @(negedge clk); m = 1; bus.data_in = dvd;
    @(negedge clk); m = 2; bus.data_in = '0;
    while (!bus.out_valid && m < 40) begin
      @(negedge clk); m++;
      bus.start = (m == pulse_m);
    end
    lat = m; r = bus.data_out; sel_r = bus.out_sel;
    @(negedge clk);
    bus.start = 1'b0;
    q = bus.data_out; sel_q = bus.out_sel; v_q = bus.out_valid; dzf = bus.dz;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; bus.start = 1'b0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.data_out !== 5'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", bus.data_out); end
    checks++; if (bus.dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %0b exp 0", bus.dz); end
    checks++; if (bus.out_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %0b exp 0", bus.out_sel); end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_basic();
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat;
    run_div(5'd4, 5'd13, -1, r, q, sr, sq, vq, dzf, lat);
    checks++; if (lat !== W + 3) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, W + 3); end
    checks++; if (r !== 5'd1) begin errors++; $display("FAIL basic_rem got %0d exp 1", r); end
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL basic_sel_r got %0b exp 0", sr); end
    checks++; if (q !== 5'd3) begin errors++; $display("FAIL basic_quo got %0d exp 3", q); end
    checks++; if (sq !== 1'b1 || vq !== 1'b1) begin errors++; $display("FAIL basic_sel_q got sel %0b valid %0b exp 1 1", sq, vq); end
    checks++; if (dzf !== 1'b0) begin errors++; $display("FAIL basic_dz got %0b exp 0", dzf); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 5'd0) begin
      errors++; $display("FAIL basic_end got valid %0b busy %0b data %0d exp 0 0 0", bus.out_valid, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] dv [4] = '{5'd1, 5'd9, 5'd31, 5'd5};
    logic [W-1:0] dd [4] = '{5'd31, 5'd7, 5'd31, 5'd0};
    logic [W-1:0] er [4] = '{5'd0, 5'd7, 5'd0, 5'd0};
    logic [W-1:0] eq [4] = '{5'd31, 5'd0, 5'd1, 5'd0};
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(dv[i], dd[i], -1, r, q, sr, sq, vq, dzf, lat);
      checks++; if (r !== er[i] || lat !== W + 3) begin errors++; $display("FAIL bound_rem %0d/%0d got %0d lat %0d exp %0d lat %0d", dd[i], dv[i], r, lat, er[i], W + 3); end
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL bound_quo %0d/%0d got %0d exp %0d", dd[i], dv[i], q, eq[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat;
    run_div(5'd0, 5'd20, -1, r, q, sr, sq, vq, dzf, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL dz_latency got %0d exp 3", lat); end
    checks++; if (r !== 5'd20) begin errors++; $display("FAIL dz_rem got %0d exp 20", r); end
    checks++; if (q !== 5'd31) begin errors++; $display("FAIL dz_quo got %0d exp 31", q); end
    checks++; if (dzf !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b exp 1", dzf); end
    repeat (5) @(negedge clk);
    checks++; if (bus.dz !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL dz_hold got dz %0b busy %0b exp 1 0", bus.dz, bus.busy); end
    run_div(5'd4, 5'd13, -1, r, q, sr, sq, vq, dzf, lat);
    checks++; if (dzf !== 1'b0 || r !== 5'd1 || q !== 5'd3) begin errors++; $display("FAIL dz_clear got dz %0b r %0d q %0d exp 0 1 3", dzf, r, q); end
  endtask

  task automatic test_reset_mid_iter();
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat, pulses;
    @(negedge clk); bus.start = 1'b1; bus.data_in = 5'd4;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.data_in = 5'd13;
    @(negedge clk); bus.data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b exp 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== 5'd0 || bus.dz !== 1'b0 || bus.out_sel !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got busy %0b valid %0b data %0d dz %0b sel %0b exp all 0",
                         bus.busy, bus.out_valid, bus.data_out, bus.dz, bus.out_sel);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_output got %0d valid cycles exp 0", pulses); end
    run_div(5'd4, 5'd13, -1, r, q, sr, sq, vq, dzf, lat);
    checks++; if (r !== 5'd1 || q !== 5'd3) begin errors++; $display("FAIL midrst_recover got r %0d q %0d exp 1 3", r, q); end
  endtask

  task automatic test_start_ignored();
    int pm [2] = '{4, W + 3};
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat, act;
    for (int i = 0; i < 2; i++) begin
      run_div(5'd4, 5'd13, pm[i], r, q, sr, sq, vq, dzf, lat);
      checks++; if (r !== 5'd1 || q !== 5'd3 || lat !== W + 3) begin
        errors++; $display("FAIL ignore_result pulse %0d got r %0d q %0d lat %0d exp 1 3 %0d", pm[i], r, q, lat, W + 3);
      end
      act = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.busy !== 1'b0) act++;
      end
      checks++; if (act !== 0) begin errors++; $display("FAIL ignore_no_requeue pulse %0d got %0d busy cycles exp 0", pm[i], act); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus.start = 1'b1; bus.data_in = 5'd4;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      case (n)
        0:       bus.data_in = 5'd4;
        1:       bus.data_in = 5'd13;
        10:      bus.data_in = 5'd3;
        11:      bus.data_in = 5'd29;
        default: bus.data_in = '0;
      endcase
      if (n == 8) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 1'b0 || bus.data_out !== 5'd1) begin
          errors++; $display("FAIL b2b_rem1 got valid %0b sel %0b data %0d exp 1 0 1", bus.out_valid, bus.out_sel, bus.data_out);
        end
      end
      if (n == 9) begin
        checks++; if (bus.out_sel !== 1'b1 || bus.data_out !== 5'd3) begin
          errors++; $display("FAIL b2b_quo1 got sel %0b data %0d exp 1 3", bus.out_sel, bus.data_out);
        end
      end
      if (n == 10) begin
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap got busy %0b valid %0b exp 0 0", bus.busy, bus.out_valid);
        end
      end
      if (n == 11) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got busy %0b exp 1", bus.busy); end
      end
      if (n == 18) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 1'b0 || bus.data_out !== 5'd2) begin
          errors++; $display("FAIL b2b_rem2 got valid %0b sel %0b data %0d exp 1 0 2", bus.out_valid, bus.out_sel, bus.data_out);
        end
      end
      if (n == 19) begin
        checks++; if (bus.out_sel !== 1'b1 || bus.data_out !== 5'd9) begin
          errors++; $display("FAIL b2b_quo2 got sel %0b data %0d exp 1 9", bus.out_sel, bus.data_out);
        end
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] r, q; logic sr, sq, vq, dzf; int lat, ri, qi;
    for (int x = 0; x < 32; x++) begin
      for (int d = 1; d < 32; d++) begin
        run_div(W'(d), W'(x), -1, r, q, sr, sq, vq, dzf, lat);
        ri = int'(r); qi = int'(q);
        checks++; if (qi * d + ri !== x || ri >= d || lat !== W + 3) begin
          errors++; $display("FAIL exh %0d/%0d got q %0d r %0d lat %0d exp q*d+r=%0d r<%0d lat %0d", x, d, qi, ri, lat, x, d, W + 3);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_reset_mid_iter();
    test_start_ignored();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
